trace_uart_tx: RTL and testbench

Debug trace transmitter sitting beside `cpu_top`, consuming its 32-bit `op` status word (packed control-path and datapath observation bits). On each cycle where the enabled trace word differs from the last captured word, it pushes the word into a small FIFO. It then serialises each word off-chip as a 5-byte UART 8N1 packet: sync byte `0xA5` followed by the word, LS byte first. A host-side receiver reconstructs the CPU's control-signal history.

---
 rtl/trace_uart_tx.sv | 117 +++++++++++
 tb/tb_trace_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_uart_tx.sv
// trace_uart_tx: captures changed trace words into a FIFO and sends each as A5 + 4 LS-first bytes over UART 8N1
module trace_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              trace_in,
  input  logic                     trace_en,
  input  logic                     ovf_clr,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q;
  logic [31:0] last_word_q, tx_word_q;
  logic [31:0] mem_q [DEPTH];
  logic last_valid_q, overflow_q, overflow_d, tx_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic [BW-1:0] baud_q;
  logic [2:0] bit_idx_q, byte_idx_q;
  logic [7:0] shift_q;
  logic capture, full, push, pop, baud_end;
  assign capture = trace_en && (!last_valid_q || trace_in != last_word_q);
  assign full = count_q == (AW+1)'(DEPTH);
  assign push = capture && !full;
  assign pop = state_q == IDLE && count_q != '0;
  assign baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign overflow_d = (capture && full) ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
  assign tx = tx_q;
  assign busy = state_q != IDLE || count_q != '0;
  assign overflow = overflow_q;
  assign fifo_count = count_q;
  // remember the last captured word so only changes are queued, even when the push is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_valid_q <= 1'b0;
      last_word_q <= '0;
    end else if (capture) begin
      last_valid_q <= 1'b1;
      last_word_q <= trace_in;
    end
  end
  // FIFO storage needs no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= trace_in;
  end
  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  // packet serialiser: sync byte then the word LS byte first, each byte framed as start, 8 data, stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q <= '0;
      tx_word_q <= '0;
      tx_q <= 1'b1;
    end else begin
      baud_q <= (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          tx_word_q <= mem_q[rd_ptr_q];
          byte_idx_q <= '0;
          shift_q <= 8'hA5;
          tx_q <= 1'b0;
          state_q <= START;
        end
        START: if (baud_end) begin
          bit_idx_q <= '0;
          tx_q <= shift_q[0];
          state_q <= DATA;
        end
        DATA: if (baud_end) begin
          shift_q <= shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            tx_q <= 1'b1;
            state_q <= STOP;
          end else begin
            bit_idx_q <= bit_idx_q + 3'd1;
            tx_q <= shift_q[1];
          end
        end
        STOP: if (baud_end) begin
          if (byte_idx_q != 3'd4) begin
            byte_idx_q <= byte_idx_q + 3'd1;
            shift_q <= tx_word_q[{byte_idx_q[1:0], 3'b000} +: 8];
            tx_q <= 1'b0;
            state_q <= START;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_uart_tx.sv
// tb_trace_uart_tx: randomized and directed checks of trace_uart_tx against a packet-level reference model
module tb_trace_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1, trace_en = 1'b0, ovf_clr = 1'b0;
  logic [31:0] trace_in = '0;
  logic tx, busy, overflow;
  logic [2:0] fifo_count;
  int total = 0, bad = 0, cyc = 0;

  trace_uart_tx #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .trace_in(trace_in), .trace_en(trace_en),
    .ovf_clr(ovf_clr), .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // reference model: queue of pending words; the line is free again 50*C+1 cycles after each pop
  logic [31:0] mq[$], exp_w[$], rx_w[$];
  int exp_t[$], rx_t[$];
  logic [31:0] m_last = '0;
  int free_at = 0, n = 0;
  bit m_lv = 0, m_ovf = 0, m_busy = 0, do_pop = 0, m_drop = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_lv = 0;
      m_ovf = 0;
      m_busy = 0;
      free_at = 0;
    end else begin
      n = mq.size();
      do_pop = n > 0 && cyc >= free_at;
      m_drop = 0;
      if (trace_en && (!m_lv || trace_in != m_last)) begin
        m_last = trace_in;
        m_lv = 1;
        if (n < D) mq.push_back(trace_in); else m_drop = 1;
      end
      m_ovf = m_drop ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
      if (do_pop) begin
        exp_w.push_back(mq.pop_front());
        exp_t.push_back(cyc + 1);
        free_at = cyc + 50 * C + 1;
      end
      m_busy = mq.size() != 0 || cyc < free_at - 1;
      cyc++;
    end
  end

  // cycle-by-cycle scoreboard of the status outputs
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (fifo_count !== 3'(mq.size())) begin
        bad++;
        $display("FAIL fifo_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, mq.size());
      end
      total++;
      if (overflow !== m_ovf) begin
        bad++;
        $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
      end
      total++;
      if (busy !== m_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy);
      end
    end
  end

  // line decoder: mid-bit sampling of 8N1 frames, grouped into 5-byte packets
  logic [7:0] mon_byte = '0;
  logic [7:0] pkt_b [5];
  int mon_t = 0, mon_start = 0, pkt_n = 0, pkt_t = 0, frame_err = 0, mon_i = 0;
  bit mon_on = 0, mon_ok = 0;
  always @(negedge clk) begin
    if (reset) begin
      mon_on = 0;
      pkt_n = 0;
    end else begin
      if (!mon_on) begin
        if (tx === 1'b0) begin
          mon_on = 1;
          mon_t = 0;
          mon_start = cyc;
          mon_ok = 1;
        end
      end else mon_t++;
      if (mon_on && mon_t % C == C / 2) begin
        mon_i = mon_t / C;
        if (mon_i == 0) mon_ok = mon_ok && tx === 1'b0;
        else if (mon_i < 9) mon_byte[mon_i-1] = tx;
        else begin
          mon_on = 0;
          if (!(mon_ok && tx === 1'b1)) frame_err++;
          if (pkt_n == 0) pkt_t = mon_start;
          pkt_b[pkt_n] = mon_byte;
          pkt_n++;
          if (pkt_n == 5) begin
            if (pkt_b[0] != 8'hA5) frame_err++;
            rx_w.push_back({pkt_b[4], pkt_b[3], pkt_b[2], pkt_b[1]});
            rx_t.push_back(pkt_t);
            pkt_n = 0;
          end
        end
      end
    end
  end

  task automatic flush();
    rx_w.delete();
    rx_t.delete();
    exp_w.delete();
    exp_t.delete();
    frame_err = 0;
  endtask

  task automatic drain(input int budget, output int idle_at);
    idle_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !mon_on) begin
        idle_at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b exp=1", tx); end
  endtask

  task automatic test_single();
    int pc, idle_at;
    flush();
    @(negedge clk); trace_in = 32'h12345678; trace_en = 1'b1;
    @(negedge clk); trace_en = 1'b0; pc = cyc;
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_push got=%0d exp=1", fifo_count); end
    @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL single_start got=%b exp=0", tx); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_pop got=%0d exp=0", fifo_count); end
    drain(400, idle_at);
    total++; if (idle_at < 0) begin bad++; $display("FAIL single_drain got=timeout exp=idle"); end
    total++; if (rx_w.size() != 1) begin bad++; $display("FAIL single_npkt got=%0d exp=1", rx_w.size()); end
    total++; if (rx_w[0] !== 32'h12345678) begin bad++; $display("FAIL single_word got=%h exp=12345678", rx_w[0]); end
    total++; if (rx_t[0] != pc + 1) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", rx_t[0], pc + 1); end
    total++; if (idle_at - rx_t[0] != 50 * C) begin bad++; $display("FAIL single_len got=%0d exp=%0d", idle_at - rx_t[0], 50 * C); end
    total++; if (frame_err != 0) begin bad++; $display("FAIL single_frame got=%0d exp=0", frame_err); end
  endtask

  task automatic test_change();
    int idle_at;
    flush();
    @(negedge clk); trace_en = 1'b1; trace_in = 32'hDEADBEEF;
    repeat (20) @(negedge clk);
    trace_in = 32'h0;
    @(negedge clk); trace_in = 32'hDEADBEEF;
    repeat (5) @(negedge clk);
    trace_en = 1'b0;
    drain(1000, idle_at);
    total++; if (idle_at < 0) begin bad++; $display("FAIL change_drain got=timeout exp=idle"); end
    total++; if (rx_w.size() != 3) begin bad++; $display("FAIL change_npkt got=%0d exp=3", rx_w.size()); end
    total++; if (rx_w[0] !== 32'hDEADBEEF || rx_w[1] !== 32'h0 || rx_w[2] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL change_words got=%h,%h,%h exp=deadbeef,00000000,deadbeef", rx_w[0], rx_w[1], rx_w[2]);
    end
    total++; if (rx_t[1] - rx_t[0] != 50 * C + 1 || rx_t[2] - rx_t[1] != 50 * C + 1) begin
      bad++; $display("FAIL change_spacing got=%0d,%0d exp=%0d", rx_t[1] - rx_t[0], rx_t[2] - rx_t[1], 50 * C + 1);
    end
    total++; if (frame_err != 0) begin bad++; $display("FAIL change_frame got=%0d exp=0", frame_err); end
  endtask

  task automatic test_overflow();
    logic [31:0] w [6];
    logic [31:0] base;
    int peak, idle_at;
    flush();
    base = $urandom;
    for (int i = 0; i < 6; i++) w[i] = {8'(8'h10 + i), base[23:0]};
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (int'(fifo_count) > peak) peak = fifo_count;
      trace_en = 1'b1; trace_in = w[i];
    end
    @(negedge clk); if (int'(fifo_count) > peak) peak = fifo_count; trace_en = 1'b0;
    @(negedge clk); if (int'(fifo_count) > peak) peak = fifo_count;
    total++; if (peak != D) begin bad++; $display("FAIL ovf_peak got=%0d exp=%0d", peak, D); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    drain(1500, idle_at);
    total++; if (idle_at < 0) begin bad++; $display("FAIL ovf_drain got=timeout exp=idle"); end
    total++; if (rx_w.size() != 5) begin bad++; $display("FAIL ovf_npkt got=%0d exp=5", rx_w.size()); end
    for (int i = 0; i < 5 && i < rx_w.size(); i++) begin
      total++; if (rx_w[i] !== w[i]) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", i, rx_w[i], w[i]); end
    end
    total++; if (frame_err != 0) begin bad++; $display("FAIL ovf_frame got=%0d exp=0", frame_err); end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_drop_clear();
    logic [31:0] w [6];
    logic [31:0] base;
    flush();
    base = $urandom;
    for (int i = 0; i < 6; i++) w[i] = {8'(8'h20 + i), base[23:16], 8'h3C, base[7:0]};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      trace_en = 1'b1; trace_in = w[i]; ovf_clr = (i == 5);
    end
    @(negedge clk); trace_en = 1'b0; ovf_clr = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL dropclr_ovf got=%b exp=1", overflow); end
    total++; if (fifo_count !== 3'(D)) begin bad++; $display("FAIL dropclr_count got=%0d exp=%0d", fifo_count, D); end
  endtask

  task automatic test_reset_mid();
    int found, lows, pc, idle_at;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pkt_n == 2 && mon_on && mon_t >= C && mon_t < 9 * C && tx === 1'b0) begin
        found = 1;
        break;
      end
    end
    total++; if (found != 1) begin bad++; $display("FAIL rstmid_reach got=%0d exp=1", found); end
    #1 reset = 1'b1;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    flush();
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    total++; if (lows != 0 || rx_w.size() != 0) begin bad++; $display("FAIL rstmid_quiet got=%0d,%0d exp=0,0", lows, rx_w.size()); end
    @(negedge clk); trace_en = 1'b1; trace_in = 32'hCAFEF00D;
    @(negedge clk); trace_en = 1'b0; pc = cyc;
    drain(400, idle_at);
    total++; if (idle_at < 0) begin bad++; $display("FAIL rstmid_drain got=timeout exp=idle"); end
    total++; if (rx_w.size() != 1 || rx_w[0] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL rstmid_word got=%0d,%h exp=1,cafef00d", rx_w.size(), rx_w[0]);
    end
    total++; if (rx_t[0] != pc + 1) begin bad++; $display("FAIL rstmid_latency got=%0d exp=%0d", rx_t[0], pc + 1); end
    total++; if (frame_err != 0) begin bad++; $display("FAIL rstmid_frame got=%0d exp=0", frame_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int idle_at;
    flush();
    a = $urandom;
    if (a == 32'hCAFEF00D) a = a ^ 32'h1;
    b = ~a;
    @(negedge clk); trace_en = 1'b1; trace_in = a;
    @(negedge clk); trace_in = b;
    @(negedge clk); trace_en = 1'b0;
    drain(800, idle_at);
    total++; if (idle_at < 0) begin bad++; $display("FAIL b2b_drain got=timeout exp=idle"); end
    total++; if (rx_w.size() != 2 || rx_w[0] !== a || rx_w[1] !== b) begin
      bad++; $display("FAIL b2b_words got=%h,%h exp=%h,%h", rx_w[0], rx_w[1], a, b);
    end
    total++; if (rx_t[1] - rx_t[0] != 50 * C + 1) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", rx_t[1] - rx_t[0], 50 * C + 1); end
  endtask

  task automatic test_random();
    logic [31:0] vals [3];
    int idle_at;
    flush();
    for (int i = 0; i < 3; i++) vals[i] = $urandom;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      trace_en = $urandom_range(0, 3) != 0;
      trace_in = vals[$urandom_range(0, 2)];
      ovf_clr = $urandom_range(0, 31) == 0;
    end
    @(negedge clk); trace_en = 1'b0; ovf_clr = 1'b0;
    drain(2000, idle_at);
    total++; if (idle_at < 0) begin bad++; $display("FAIL rand_drain got=timeout exp=idle"); end
    total++; if (rx_w.size() != exp_w.size()) begin bad++; $display("FAIL rand_npkt got=%0d exp=%0d", rx_w.size(), exp_w.size()); end
    for (int i = 0; i < rx_w.size() && i < exp_w.size(); i++) begin
      total++; if (rx_w[i] !== exp_w[i]) begin bad++; $display("FAIL rand_word%0d got=%h exp=%h", i, rx_w[i], exp_w[i]); end
      total++; if (rx_t[i] != exp_t[i]) begin bad++; $display("FAIL rand_time%0d got=%0d exp=%0d", i, rx_t[i], exp_t[i]); end
    end
    total++; if (frame_err != 0) begin bad++; $display("FAIL rand_frame got=%0d exp=0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_change();
    test_overflow();
    test_drop_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
